// File: rtl/xilinx_phy10g_qpll_reset_seq.sv
// QPLL reset/lock sequencer: pulse qpllreset_o, wait for a stable lock, flag ready, and retry on timeout or lock loss.
// Latency: qplllock_i reaches the FSM through a 2-flop synchronizer; all outputs are registered one cycle after the FSM decision.
// Backpressure: none; free-running sequencer. Optional retry_cnt_o when XILINX_PHY10G_QPLL_RETRY_CNT_EN is defined.
module xilinx_phy10g_qpll_reset_seq #(
    parameter int RESET_CYCLES  = 128,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       qplllock_i,
    output logic       qpllreset_o,
    output logic       qpll_ready_o,
    output logic       lock_lost_o,
    output logic       timeout_o
`ifdef XILINX_PHY10G_QPLL_RETRY_CNT_EN
    ,
    output logic [7:0] retry_cnt_o
`endif
);

    localparam int MAX_A  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W  = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lock_meta, lock_s;
    logic             timeout_nxt, lost_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= qplllock_i;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_ONE;
        timeout_nxt = 1'b0;
        lost_nxt    = 1'b0;
        case (state)
            ST_RESET: begin
                if (cnt == RC_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == LT_LAST) begin
                    state_nxt   = ST_RESET;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                end
            end
            ST_STABLE: begin
                // a lock drop wins over the terminal count
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == SC_LAST) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end
            end
            ST_READY: begin
                cnt_nxt = cnt;
                if (!lock_s) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                    lost_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_RESET;
            cnt          <= '0;
            qpllreset_o  <= 1'b1;
            qpll_ready_o <= 1'b0;
            lock_lost_o  <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            qpllreset_o  <= (state_nxt == ST_RESET);
            qpll_ready_o <= (state_nxt == ST_READY);
            lock_lost_o  <= lost_nxt;
            timeout_o    <= timeout_nxt;
        end
    end

`ifdef XILINX_PHY10G_QPLL_RETRY_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_cnt_o <= 8'd0;
        end else if ((timeout_nxt || lost_nxt) && (retry_cnt_o != 8'hFF)) begin
            retry_cnt_o <= retry_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xilinx_phy10g_qpll_reset_seq.sv
// Scoreboard bench for the QPLL reset sequencer: a deadline-based reference model predicts output events,
// a negedge monitor turns DUT output changes into events and matches them against the expected queue.
module tb_xilinx_phy10g_qpll_reset_seq;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_READY  = 3;

    // event kinds: 0 reset rise, 1 reset fall, 2 ready rise, 3 ready fall, 4 timeout, 5 lock lost, 6 retry count change
    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic qplllock_i = 1'b0;
    logic qpllreset_o, qpll_ready_o, lock_lost_o, timeout_o;
`ifdef XILINX_PHY10G_QPLL_RETRY_CNT_EN
    logic [7:0] retry_cnt_o;
`endif

    xilinx_phy10g_qpll_reset_seq #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .qplllock_i  (qplllock_i),
        .qpllreset_o (qpllreset_o),
        .qpll_ready_o(qpll_ready_o),
        .lock_lost_o (lock_lost_o),
        .timeout_o   (timeout_o)
`ifdef XILINX_PHY10G_QPLL_RETRY_CNT_EN
        ,
        .retry_cnt_o (retry_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    // reference model: phase plus the edge number at which it was entered
    int   m_phase = P_RESET;
    int   m_entry = 0;
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    int   m_retry = 0;
    bit   m_prv_rst = 1'b0, m_prv_rdy = 1'b0;
    int   m_prv_retry = 0;

    task automatic push_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = cyc;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic model_edge(input logic r, input logic l);
        logic ls;
        bit   to, ll, o_rst, o_rdy;
        ls = m_s2;
        to = 1'b0;
        ll = 1'b0;
        if (r) begin
            m_phase = P_RESET;
            m_entry = cyc;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_retry = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = l;
            case (m_phase)
                P_RESET: if (cyc == m_entry + RC) begin m_phase = P_WAIT; m_entry = cyc; end
                P_WAIT: begin
                    if (ls) begin m_phase = P_STABLE; m_entry = cyc; end
                    else if (cyc == m_entry + LT) begin m_phase = P_RESET; m_entry = cyc; to = 1'b1; end
                end
                P_STABLE: begin
                    if (!ls) begin m_phase = P_WAIT; m_entry = cyc; end
                    else if (cyc == m_entry + SC) begin m_phase = P_READY; m_entry = cyc; end
                end
                default: if (!ls) begin m_phase = P_RESET; m_entry = cyc; ll = 1'b1; end
            endcase
            if ((to || ll) && m_retry < 255) m_retry++;
        end
        o_rst = (m_phase == P_RESET);
        o_rdy = (m_phase == P_READY);
        if (o_rst && !m_prv_rst) push_ev(0, 0);
        if (!o_rst && m_prv_rst) push_ev(1, 0);
        if (o_rdy && !m_prv_rdy) push_ev(2, 0);
        if (!o_rdy && m_prv_rdy) push_ev(3, 0);
        if (to) push_ev(4, 0);
        if (ll) push_ev(5, 0);
`ifdef XILINX_PHY10G_QPLL_RETRY_CNT_EN
        if (m_retry != m_prv_retry) push_ev(6, m_retry);
`endif
        m_prv_rst   = o_rst;
        m_prv_rdy   = o_rdy;
        m_prv_retry = m_retry;
    endtask

    task automatic step(input logic r, input logic l);
        rst_i      = r;
        qplllock_i = l;
        @(posedge clk_i);
        cyc++;
        model_edge(r, l);
        #1;
    endtask

    task automatic check_ev(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got kind=%0d val=%0d, none expected", cyc, k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                errors++;
                $display("FAIL event_match got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d",
                         k, cyc, v, e.kind, e.cyc, e.val);
            end
        end
    endtask

    bit d_prv_rst = 1'b0, d_prv_rdy = 1'b0;
    int d_prv_retry = 0;

    always @(negedge clk_i) begin
        if (mon_en && cyc > 0) begin
            checks++;
            if ((lock_lost_o === 1'b1) && (timeout_o === 1'b1)) begin
                errors++;
                $display("FAIL pulse_exclusive cyc=%0d got lock_lost=1 timeout=1 required not both", cyc);
            end
            if ((qpllreset_o === 1'b1) && !d_prv_rst) check_ev(0, 0);
            if ((qpllreset_o !== 1'b1) && d_prv_rst) check_ev(1, 0);
            if ((qpll_ready_o === 1'b1) && !d_prv_rdy) check_ev(2, 0);
            if ((qpll_ready_o !== 1'b1) && d_prv_rdy) check_ev(3, 0);
            if (timeout_o === 1'b1) check_ev(4, 0);
            if (lock_lost_o === 1'b1) check_ev(5, 0);
`ifdef XILINX_PHY10G_QPLL_RETRY_CNT_EN
            if (int'(retry_cnt_o) != d_prv_retry) check_ev(6, int'(retry_cnt_o));
            d_prv_retry = int'(retry_cnt_o);
`endif
            d_prv_rst = (qpllreset_o === 1'b1);
            d_prv_rdy = (qpll_ready_o === 1'b1);
        end
    end

    initial begin
        int mode, len;
        logic lv;
        mon_en = 1'b1;

        // constant lock after reset release
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1);

        // lock lost while ready, then held low for three timeouts
        for (int i = 0; i < 3 * (RC + LT) + 10; i++) step(1'b0, 1'b0);

        // one-cycle glitch inside the stable window
        step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1);

        // single-cycle drop while ready
        step(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1);

        // reset in the middle of the lock wait
        step(1'b1, 1'b0);
        for (int i = 0; i < RC + 20; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // randomized lock waveform with occasional resets
        for (int i = 0; i < 100; i++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                len = $urandom_range(1, 2);
                lv  = 1'($urandom_range(0, 1));
                for (int j = 0; j < len; j++) step(1'b1, lv);
            end else begin
                if (mode < 4)       begin lv = 1'b0; len = $urandom_range(1, 5);   end
                else if (mode < 5)  begin lv = 1'b0; len = $urandom_range(30, 80); end
                else                begin lv = 1'b1; len = $urandom_range(5, 40);  end
                for (int j = 0; j < len; j++) step(1'b0, lv);
            end
        end

`ifdef XILINX_PHY10G_QPLL_RETRY_CNT_EN
        // drive the retry counter into saturation, then clear it
        step(1'b1, 1'b0);
        for (int i = 0; i < 300 * (RC + LT) + 20; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
`endif

        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got %0d still pending, required 0 (next kind=%0d cyc=%0d)",
                     exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
